// File: rtl/serial_frame_sequencer_if.sv
// Bus bundle between the serial front end / transmitter side and the
// serial_frame_sequencer. The master drives the line, frame strobe and
// transmitter ready; the slave (sequencer) drives everything else.
`timescale 1ns/1ps
interface serial_frame_sequencer_if #(
    parameter int DATA_W = 8
) ();
    localparam int CW = $clog2(DATA_W + 1);

    logic              serial_in;
    logic              rise;
    logic              data_ready;
    logic              shift_en;
    logic [CW-1:0]     bit_idx;
    logic              busy;
    logic              wake_transmitter;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              overrun;
    logic              parity_err;

    modport master (
        output serial_in, rise, data_ready,
        input  shift_en, bit_idx, busy, wake_transmitter,
        input  data_out, data_valid, overrun, parity_err
    );

    modport slave (
        input  serial_in, rise, data_ready,
        output shift_en, bit_idx, busy, wake_transmitter,
        output data_out, data_valid, overrun, parity_err
    );
endinterface

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer: schedules one serial frame per frame-start strobe,
// shifts DATA_W bits LSB-first, then hands the word to the transmitter via a
// one-entry holding register (valid/ready). A completed frame arriving while
// the holding register is still full and not being drained is dropped and
// flagged with an overrun pulse.
// Optional feature macro: PARITY_EN -- adds a trailing even-parity bit per
// frame; a failing frame pulses parity_err and is not loaded.
`timescale 1ns/1ps
module serial_frame_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    serial_frame_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DATA_W + 1);
`ifdef PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam logic [CW-1:0] LP_DW   = CW'(DATA_W);
    localparam logic [CW-1:0] LP_LAST = CW'(NBITS - 1);
    localparam logic [CW-1:0] LP_WAKE = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_shift_en;
    logic              r_wake;
    logic              r_overrun;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_frame_bad;

    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef PARITY_EN
    logic r_par_err;

    // Even parity of a data word: the trailing bit must make the total even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // parity_err is high exactly during DONE, so it doubles as the reject flag.
    assign w_frame_bad    = r_par_err;
    assign bus.parity_err = r_par_err;
`else
    assign w_frame_bad    = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    // Frame FSM: sequencing, bit shifting, holding register handshake, pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_shift_en <= 1'b0;
            r_wake     <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_shift_en <= 1'b0;
            r_wake     <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef PARITY_EN
            r_par_err  <= 1'b0;
`endif
            // Transmitter drain; a DONE load below on the same edge overrides it.
            if (r_valid && bus.data_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.rise) begin
                        r_state    <= ST_RECV;
                        r_busy     <= 1'b1;
                        r_shift_en <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                ST_RECV: begin
                    // Data bits enter at the MSB so the first bit ends in the LSB.
                    if (r_cnt < LP_DW) begin
                        r_sr <= {bus.serial_in, r_sr[DATA_W-1:1]};
                    end else begin
                        r_sr <= r_sr;
                    end
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
`ifdef PARITY_EN
                        r_par_err <= even_par(r_sr) ^ bus.serial_in;
`endif
                    end else begin
                        r_state    <= ST_RECV;
                        r_cnt      <= w_cnt_inc;
                        r_shift_en <= (w_cnt_inc < LP_DW);
                        r_wake     <= (w_cnt_inc == LP_WAKE);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    if (w_frame_bad) begin
                        r_overrun <= 1'b0;
                    end else if (!r_valid || bus.data_ready) begin
                        r_data  <= r_sr;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.shift_en         = r_shift_en;
    assign bus.bit_idx          = r_cnt;
    assign bus.busy             = r_busy;
    assign bus.wake_transmitter = r_wake;
    assign bus.data_out         = r_data;
    assign bus.data_valid       = r_valid;
    assign bus.overrun          = r_overrun;
endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Self-checking bench for serial_frame_sequencer. A frame-age model (cycles
// since the accepted frame start) predicts every output each cycle; directed
// frames with hand-computed words pin the model.
`timescale 1ns/1ps
module tb_serial_frame_sequencer;
    localparam int DW = 8;
    localparam int IW = $clog2(DW);
`ifdef PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_sequencer_if #(.DATA_W(DW)) bus ();

    serial_frame_sequencer #(.DATA_W(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int shift_total = 0, wake_total = 0, ovr_total = 0, perr_total = 0, vlow_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k: -1 idle, 0..NB-1 receiving bit m_k, NB = completion cycle.
    int          m_k = -1;
    logic [DW-1:0] m_sr   = '0;
    logic [DW-1:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic        m_par   = 1'b0;
    logic        m_good;
`ifdef PARITY_EN
    assign m_good = ((^m_sr) == m_par);
`else
    assign m_good = 1'b1;
`endif

    // Model: bit k of the frame is captured at the edge that ends age k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= -1; m_sr <= '0; m_data <= '0; m_valid <= 1'b0; m_ovr <= 1'b0; m_par <= 1'b0;
        end else begin
            m_ovr <= 1'b0;
            if (m_valid && bus.data_ready) m_valid <= 1'b0;
            if (m_k < 0) begin
                if (bus.rise) m_k <= 0;
            end else if (m_k < NB) begin
                if (m_k < DW) m_sr[m_k[IW-1:0]] <= bus.serial_in;
                else          m_par <= bus.serial_in;
                m_k <= m_k + 1;
            end else begin
                m_k <= -1;
                if (m_good && (!m_valid || bus.data_ready)) begin
                    m_data  <= m_sr;
                    m_valid <= 1'b1;
                end else if (m_good) begin
                    m_ovr <= 1'b1;
                end
            end
        end
    end

    // Compare every output against the model each cycle, just after the edge.
    always @(posedge clk) begin
        #1;
        chk("busy",  32'(bus.busy),             32'(m_k >= 0));
        chk("shift", 32'(bus.shift_en),         32'(m_k >= 0 && m_k < DW));
        chk("idx",   32'(bus.bit_idx),          32'((m_k >= 0 && m_k < NB) ? m_k : 0));
        chk("wake",  32'(bus.wake_transmitter), 32'(m_k == DW - 1));
        chk("data",  32'(bus.data_out),         32'(m_data));
        chk("valid", 32'(bus.data_valid),       32'(m_valid));
        chk("ovr",   32'(bus.overrun),          32'(m_ovr));
`ifdef PARITY_EN
        chk("perr",  32'(bus.parity_err),       32'(m_k == NB && !m_good));
`else
        chk("perr",  32'(bus.parity_err),       32'(0));
`endif
        if (bus.shift_en === 1'b1)         shift_total++;
        if (bus.wake_transmitter === 1'b1) wake_total++;
        if (bus.overrun === 1'b1)          ovr_total++;
        if (bus.parity_err === 1'b1)       perr_total++;
        if (bus.data_valid !== 1'b1)       vlow_total++;
    end

    // ---------------- stimulus ----------------
    // Start strobe, DW bits LSB first (then parity), return in the completion cycle.
    task automatic send_frame(input logic [DW-1:0] w, input bit par_flip,
                              input bit hold_rise, input bit done_ready);
        @(negedge clk); bus.rise = 1'b1;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk); bus.rise = hold_rise; bus.serial_in = w[i];
        end
`ifdef PARITY_EN
        @(negedge clk); bus.serial_in = (^w) ^ par_flip;
`else
        if (par_flip) bus.serial_in = 1'b0;
`endif
        @(negedge clk); bus.serial_in = 1'b0;
        if (done_ready) bus.data_ready = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk); bus.data_ready = 1'b1;
        @(negedge clk); bus.data_ready = 1'b0;
    endtask

    int s0, w0, o0, v0, p0;

    initial begin
        bus.serial_in = 1'b0; bus.rise = 1'b0; bus.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_data",  32'(bus.data_out),   32'h0);

        // Reset in the middle of a frame, then a clean 0x3C frame.
        @(negedge clk); bus.rise = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.rise = 1'b0; bus.serial_in = 1'b1;
        end
        @(negedge clk); rst_n = 1'b0; bus.serial_in = 1'b0; #1;
        chk("midrst_busy",  32'(bus.busy),     32'h0);
        chk("midrst_shift", 32'(bus.shift_en), 32'h0);
        chk("midrst_idx",   32'(bus.bit_idx),  32'h0);
        @(negedge clk); rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("f3c_data",  32'(bus.data_out),   32'h3C);
        chk("f3c_valid", 32'(bus.data_valid), 32'h1);
        drain();

        // 0xA5 with transmitter always ready: valid for exactly one cycle.
        @(negedge clk); bus.data_ready = 1'b1;
        w0 = wake_total;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("a5_data",  32'(bus.data_out),   32'hA5);
        chk("a5_valid", 32'(bus.data_valid), 32'h1);
        @(posedge clk); #2;
        chk("a5_clear", 32'(bus.data_valid), 32'h0);
        chk("a5_wake",  32'(wake_total - w0), 32'd1);
        @(negedge clk); bus.data_ready = 1'b0;

        // 0x12 then 0x34 with no drain: second frame dropped.
        o0 = ovr_total;
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("ovr_data",  32'(bus.data_out), 32'h12);
        chk("ovr_pulse", 32'(bus.overrun),  32'h1);
        @(posedge clk); #2;
        chk("ovr_count", 32'(ovr_total - o0), 32'd1);
        chk("ovr_keep",  32'(bus.data_out), 32'h12);
        drain();

        // Drain coincides with the second completion: seamless hand-over.
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("hand_first", 32'(bus.data_out), 32'h12);
        v0 = vlow_total; o0 = ovr_total;
        send_frame(8'h34, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk("hand_second", 32'(bus.data_out),   32'h34);
        chk("hand_valid",  32'(bus.data_valid), 32'h1);
        @(negedge clk); bus.data_ready = 1'b0;
        chk("hand_nogap",  32'(vlow_total - v0), 32'd0);
        chk("hand_noovr",  32'(ovr_total - o0),  32'd0);
        drain();

        // Strobe held high throughout the frame: still exactly DW samples.
        s0 = shift_total;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        @(negedge clk); bus.rise = 1'b0;
        chk("hold_shifts", 32'(shift_total - s0), 32'd8);
        chk("hold_data",   32'(bus.data_out),     32'h5A);
        repeat (2) @(negedge clk);
        chk("hold_idle",   32'(bus.busy),         32'h0);
        drain();

`ifdef PARITY_EN
        // 0x0F has even weight: parity bit 0 is good, 1 is a failure.
        p0 = perr_total;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("par_bad_valid", 32'(bus.data_valid),    32'h0);
        chk("par_bad_pulse", 32'(perr_total - p0),   32'd1);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("par_ok_data",  32'(bus.data_out),   32'h0F);
        chk("par_ok_valid", 32'(bus.data_valid), 32'h1);
        chk("par_ok_pulse", 32'(perr_total - p0), 32'd1);
        drain();
`else
        p0 = perr_total;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("np_data",  32'(bus.data_out),    32'h0F);
        chk("np_perr",  32'(perr_total - p0), 32'd0);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_frame_sequencer.md
# serial_frame_sequencer

Controller that sequences the serial receive datapath: it detects a frame start, drives the bit-shift enable for exactly one frame, counts bits, and hands the assembled word to the transmitter side through a one-entry holding register with a valid/ready handshake. It sits between the serial line front end and the transmitter, and replaces free-running counter/shift-register pairing with explicit frame scheduling and overrun detection.

## Interface
- DATA_W, 8, data bits per frame (2..16)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- serial_in  input  1  serial data bit, sampled on clk while receiving
- rise  input  1  frame-start strobe, one cycle wide
- data_ready  input  1  transmitter accepts data_out this cycle
- shift_en  output  1  high on each cycle a data bit is sampled
- bit_idx  output  $clog2(DATA_W+1)  index of bit being sampled, 0 when idle
- busy  output  1  high in RECV and DONE
- wake_transmitter  output  1  one-cycle pulse on the last data bit sample
- data_out  output  DATA_W  holding register contents
- data_valid  output  1  holding register occupied
- overrun  output  1  one-cycle pulse when a completed frame is dropped
- parity_err  output  1  one-cycle pulse on parity failure (see Configuration)

## Operation
- States: IDLE, RECV, DONE.
- IDLE: bit_idx=0, shift_en=0. rise=1 -> RECV, bit counter cleared.
- RECV: every cycle shift_en=1; shift register loads {serial_in, sr[DATA_W-1:1]} (first bit ends in LSB). Counter increments; after DATA_W samples -> DONE. rise during RECV/DONE ignored.
- wake_transmitter=1 on the cycle bit_idx==DATA_W-1.
- DONE (one cycle): if holding register empty, or full and data_ready=1 this cycle -> load shift register into data_out, data_valid=1. If full and data_ready=0 -> frame dropped, overrun=1, old data kept. Always -> IDLE.
- Handshake: data_valid && data_ready at an edge clears data_valid unless a DONE load occurs on the same edge. data_out stable while data_valid=1 and not consumed.
- rise in DONE cycle ignored; a new frame needs rise in IDLE.
- Reset (any time, incl. mid-frame): state IDLE, counter 0, shift register 0, data_out 0, data_valid 0, all pulses 0; partial frame discarded.

## Timing
- rise=1 at edge N -> RECV from N; bits sampled at edges N+1..N+DATA_W.
- data_out/data_valid updated at edge N+DATA_W+1; earliest next rise accepted at edge N+DATA_W+2 (back-to-back frame period DATA_W+2 cycles).
- wake_transmitter high in the cycle before edge N+DATA_W.
- All outputs registered or decoded from registered state; no combinational path from data_ready to data_valid.

## Configuration
- PARITY_EN defined: RECV samples DATA_W+1 bits; final bit is even parity, not shifted into data; shift_en stays 0 on the parity cycle; bit_idx reaches DATA_W; timing above shifts by one cycle. On mismatch: parity_err pulses in DONE, frame not loaded, overrun not raised.
- PARITY_EN undefined: DATA_W bits only, parity_err tied 0.

## Test plan
- Reset low mid-frame (after 3 bits) -> all outputs 0, state IDLE; next frame 0x3C received intact.
- rise, serial bits of 0xA5 LSB-first, data_ready=1 -> data_out=0xA5, data_valid=1 at edge N+9, cleared next edge; wake_transmitter one pulse.
- Two frames 0x12 then 0x34, data_ready=0 -> data_out stays 0x12, overrun pulses once; frame 0x34 lost.
- Second frame DONE coincides with data_ready=1 -> data_out 0x12 then 0x34 with data_valid continuously high, no overrun.
- rise asserted repeatedly during RECV -> ignored, frame length exactly DATA_W samples (count shift_en=8).
- PARITY_EN: 0x0F with parity bit 1 -> parity_err pulse, data_valid stays 0; with parity bit 0 -> loaded normally.
